secuenciador_alerta: RTL and testbench
======================================

# secuenciador_alerta

Sampling and decision sequencer for the cabin gas-alarm datapath. It paces the sensor ADC, strobes the alert-flag generator to latch each new sample, and then pulses `activar_decidir` into the activation logic. It reads back the combinational `peligro` flag to switch between normal and fast sampling rates, and it watchdogs the ADC for missing conversions.

## Interface
- `PERIODO_NORMAL`, default 50_000_000: cycles spent in ESPERA in normal mode (1 s at 50 MHz).
- `PERIODO_PELIGRO`, default 5_000_000: cycles spent in ESPERA in danger mode.
- `T_CONV_MAX`, default 1000: ADC conversion timeout, in cycles.
- `N_LIBRE`, default 3: number of consecutive clean decisions required to leave danger mode.
- `CNT_W`, default 26: counter width. Must satisfy 2^CNT_W > max(PERIODO_NORMAL, T_CONV_MAX).
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `ignicion`  in  1  synchronized ignition.
- `adc_done`  in  1  ADC conversion complete, one-cycle pulse.
- `peligro`  in  1  combinational danger flag from the activation logic.
- `adc_inicio`  out  1  start ADC conversion.
- `cargar_alerta`  out  1  latch new alert flags.
- `activar_decidir`  out  1  register the alarm and ventilation decision.
- `modo_peligro`  out  1  fast-sampling mode active.
- `error_sensor`  out  1  sticky ADC timeout flag.

## Operation
- FSM states: ESPERA, INICIO, CONVIERTE, CARGA, DECIDE.
- `adc_inicio`, `cargar_alerta` and `activar_decidir` are Moore decodes of the registered state. Each is high for exactly one cycle, in INICIO, CARGA and DECIDE respectively.
- **ESPERA:** the down-counter decrements each cycle. When it reads 0, the FSM moves to INICIO.
- **INICIO:** moves to CONVIERTE. The timeout counter is loaded with T_CONV_MAX-1.
- **CONVIERTE:**
  - If `adc_done` is high, move to CARGA.
  - Otherwise, if the timeout counter is 0: set `error_sensor`, set `modo_peligro`, clear the libre count, load the ESPERA counter with PERIODO_PELIGRO-1, and move to ESPERA. CARGA and DECIDE are skipped.
  - If `adc_done` and timeout expiry occur in the same cycle, `adc_done` wins.
- **CARGA:** moves to DECIDE.
- **DECIDE:** `peligro` is sampled this cycle, because the alert flags were updated in CARGA.
  - If `ignicion`=1: `modo_peligro` is cleared and the libre count is cleared.
  - Else if `peligro`=1: `modo_peligro` is set and the libre count is cleared.
  - Else: the libre count increments, saturating at N_LIBRE. When the count reaches N_LIBRE, `modo_peligro` clears.
  - The ESPERA counter is loaded with (next `modo_peligro` ? PERIODO_PELIGRO : PERIODO_NORMAL) - 1. The FSM then moves to ESPERA.
- `adc_done` is ignored outside CONVIERTE.
- `error_sensor` clears only on `rst`. Sequencing continues after an error.

## Timing
- **Reset values:** state ESPERA, ESPERA counter 0, all outputs 0, libre count 0.
- The first clk edge after `rst` deasserts enters INICIO, so `adc_inicio` is high in cycle 1.
- **Sample interval** (INICIO to INICIO) = 3 + C + P cycles, where C is the number of CONVIERTE cycles up to and including the `adc_done` cycle, and P is the selected period.
- **Timeout path:** C = T_CONV_MAX. The next INICIO occurs 1 + T_CONV_MAX + PERIODO_PELIGRO cycles after the previous INICIO.
- `modo_peligro` and `error_sensor` update on the edge that leaves DECIDE or CONVIERTE, respectively.
- `rst` asserted mid-operation forces the reset values immediately. Any pending conversion is abandoned.

## Configuration
- **`ALERTA_TIMEOUT_EN` defined:** the timeout counter, the error path and `error_sensor` are implemented as described above.
- **`ALERTA_TIMEOUT_EN` undefined:** CONVIERTE waits indefinitely for `adc_done`, `error_sensor` is tied to 0, and T_CONV_MAX is unused.

## Structure
- **Package `alerta_pkg`:** state encoding localparams, the Encendido/Apagado constants, and default period values.
- **Sub-module `contador_carga`:** a loadable down-counter with load, enable and zero flag, CNT_W wide. It is instantiated once for ESPERA and once for the timeout.
- The top level holds the FSM, the libre counter and the mode/error registers.

## Test plan
All scenarios use PERIODO_NORMAL=10, PERIODO_PELIGRO=4, T_CONV_MAX=5, N_LIBRE=3.
- **Nominal loop:** `adc_done` two cycles after `adc_inicio`, `peligro`=0 → INICIO-to-INICIO interval of 15 cycles, one pulse each of `cargar_alerta` and `activar_decidir`, `modo_peligro`=0.
- **Danger entry/exit:** `peligro`=1 in one DECIDE → `modo_peligro`=1 and interval 9. Then three clean DECIDEs → `modo_peligro` drops after the third, and the next interval is 15.
- **Ignition override:** `peligro`=1 with `ignicion`=1 → `modo_peligro` stays 0 and the interval stays 15.
- **Timeout** (macro defined): no `adc_done` → after 5 CONVIERTE cycles, `error_sensor`=1, `modo_peligro`=1, no `activar_decidir` pulse, and the next `adc_inicio` follows 4 cycles of ESPERA.
- **Simultaneous events:** `adc_done` in the timeout-expiry cycle → CARGA is entered and `error_sensor` stays 0.
- **Reset mid-conversion:** `rst` asserted in CONVIERTE → all outputs 0 immediately, and `adc_inicio` occurs in cycle 1 after release.

Source files
------------

// File: rtl/alerta_pkg.sv
// Shared definitions for the cabin gas-alarm sequencer: state encoding,
// on/off constants and default timing values.
package alerta_pkg;

    localparam logic [2:0] ST_ESPERA    = 3'd0;
    localparam logic [2:0] ST_INICIO    = 3'd1;
    localparam logic [2:0] ST_CONVIERTE = 3'd2;
    localparam logic [2:0] ST_CARGA     = 3'd3;
    localparam logic [2:0] ST_DECIDE    = 3'd4;

    typedef enum logic [2:0] {
        ESPERA    = ST_ESPERA,
        INICIO    = ST_INICIO,
        CONVIERTE = ST_CONVIERTE,
        CARGA     = ST_CARGA,
        DECIDE    = ST_DECIDE
    } estado_t;

    localparam logic ENCENDIDO = 1'b1;
    localparam logic APAGADO   = 1'b0;

    localparam int unsigned PERIODO_NORMAL_DEF  = 50_000_000;
    localparam int unsigned PERIODO_PELIGRO_DEF = 5_000_000;
    localparam int unsigned T_CONV_MAX_DEF      = 1000;
    localparam int unsigned N_LIBRE_DEF         = 3;
    localparam int unsigned CNT_W_DEF           = 26;

endpackage

// File: rtl/contador_carga.sv
// Loadable down-counter with enable and zero flag; stops at zero.
module contador_carga import alerta_pkg::*; #(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_cargar,
    input  logic             i_habilitar,
    input  logic [CNT_W-1:0] i_valor,
    output logic             o_cero_c
);

    logic [CNT_W-1:0] r_cuenta;

    // Load has priority over counting; the count holds once it reaches zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cuenta <= '0;
        end else if (i_cargar) begin
            r_cuenta <= i_valor;
        end else if (i_habilitar && (r_cuenta != '0)) begin
            r_cuenta <= r_cuenta - CNT_W'(1);
        end
    end

    assign o_cero_c = (r_cuenta == '0);

endmodule

// File: rtl/secuenciador_alerta.sv
// Sampling/decision sequencer for the cabin gas alarm: paces the ADC, strobes
// the alert-flag latch and the decision register, and selects normal or fast
// sampling from the danger flag.
// Optional macro ALERTA_TIMEOUT_EN adds the ADC conversion watchdog and the
// sticky error_sensor flag; without it CONVIERTE waits for adc_done forever.
module secuenciador_alerta import alerta_pkg::*; #(
    parameter int unsigned PERIODO_NORMAL  = PERIODO_NORMAL_DEF,
    parameter int unsigned PERIODO_PELIGRO = PERIODO_PELIGRO_DEF,
    parameter int unsigned T_CONV_MAX      = T_CONV_MAX_DEF,
    parameter int unsigned N_LIBRE         = N_LIBRE_DEF,
    parameter int unsigned CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic ignicion,
    input  logic adc_done,
    input  logic peligro,
    output logic adc_inicio,
    output logic cargar_alerta,
    output logic activar_decidir,
    output logic modo_peligro,
    output logic error_sensor
);

    localparam int unsigned LIBRE_W    = $clog2(N_LIBRE + 1);
    localparam int unsigned MAX_CUENTA = (PERIODO_NORMAL > T_CONV_MAX) ? PERIODO_NORMAL : T_CONV_MAX;

    localparam logic [CNT_W-1:0]   CUENTA_NORMAL  = CNT_W'(PERIODO_NORMAL - 1);
    localparam logic [CNT_W-1:0]   CUENTA_PELIGRO = CNT_W'(PERIODO_PELIGRO - 1);
    localparam logic [LIBRE_W-1:0] LIBRE_MAX      = LIBRE_W'(N_LIBRE);

    // Counters must be able to hold the longest interval they are loaded with.
    if ((64'd1 << CNT_W) <= 64'(MAX_CUENTA)) begin : g_cnt_w_invalido
        $error("secuenciador_alerta: CNT_W too small for PERIODO_NORMAL/T_CONV_MAX");
    end

    estado_t            r_estado, w_estado_sig;
    logic [LIBRE_W-1:0] r_libre, w_libre_sig;
    logic               r_modo, w_modo_sig;
    logic               r_adc_inicio, r_cargar, r_decidir;
    logic               w_esp_cargar, w_esp_hab, w_esp_cero;
    logic [CNT_W-1:0]   w_esp_valor;
`ifdef ALERTA_TIMEOUT_EN
    logic               r_error, w_error_sig;
    logic               w_to_cargar, w_to_hab, w_to_cero;
`endif

    // Wait interval between samples.
    contador_carga #(.CNT_W(CNT_W)) u_cnt_espera (
        .clk        (clk),
        .rst        (rst),
        .i_cargar   (w_esp_cargar),
        .i_habilitar(w_esp_hab),
        .i_valor    (w_esp_valor),
        .o_cero_c   (w_esp_cero)
    );

`ifdef ALERTA_TIMEOUT_EN
    // ADC conversion watchdog.
    contador_carga #(.CNT_W(CNT_W)) u_cnt_timeout (
        .clk        (clk),
        .rst        (rst),
        .i_cargar   (w_to_cargar),
        .i_habilitar(w_to_hab),
        .i_valor    (CNT_W'(T_CONV_MAX - 1)),
        .o_cero_c   (w_to_cero)
    );
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado <= ESPERA;
        end else begin
            r_estado <= w_estado_sig;
        end
    end

    // Next state, counter control and next mode/libre/error values.
    always_comb begin
        w_estado_sig = r_estado;
        w_libre_sig  = r_libre;
        w_modo_sig   = r_modo;
        w_esp_cargar = APAGADO;
        w_esp_hab    = APAGADO;
        w_esp_valor  = CUENTA_NORMAL;
`ifdef ALERTA_TIMEOUT_EN
        w_error_sig  = r_error;
        w_to_cargar  = APAGADO;
        w_to_hab     = APAGADO;
`endif
        case (r_estado)
            ESPERA: begin
                w_esp_hab = ENCENDIDO;
                if (w_esp_cero) begin
                    w_estado_sig = INICIO;
                end
            end
            INICIO: begin
`ifdef ALERTA_TIMEOUT_EN
                w_to_cargar = ENCENDIDO;
`endif
                w_estado_sig = CONVIERTE;
            end
            CONVIERTE: begin
`ifdef ALERTA_TIMEOUT_EN
                w_to_hab = ENCENDIDO;
                if (adc_done) begin
                    w_estado_sig = CARGA;
                end else if (w_to_cero) begin
                    w_error_sig  = ENCENDIDO;
                    w_modo_sig   = ENCENDIDO;
                    w_libre_sig  = '0;
                    w_esp_cargar = ENCENDIDO;
                    w_esp_valor  = CUENTA_PELIGRO;
                    w_estado_sig = ESPERA;
                end
`else
                if (adc_done) begin
                    w_estado_sig = CARGA;
                end
`endif
            end
            CARGA: begin
                w_estado_sig = DECIDE;
            end
            DECIDE: begin
                if (ignicion) begin
                    w_modo_sig  = APAGADO;
                    w_libre_sig = '0;
                end else if (peligro) begin
                    w_modo_sig  = ENCENDIDO;
                    w_libre_sig = '0;
                end else begin
                    if (r_libre < LIBRE_MAX) begin
                        w_libre_sig = r_libre + LIBRE_W'(1);
                    end
                    if (w_libre_sig == LIBRE_MAX) begin
                        w_modo_sig = APAGADO;
                    end
                end
                w_esp_cargar = ENCENDIDO;
                w_esp_valor  = w_modo_sig ? CUENTA_PELIGRO : CUENTA_NORMAL;
                w_estado_sig = ESPERA;
            end
            default: begin
                w_estado_sig = ESPERA;
            end
        endcase
    end

    // Mode, libre count and strobes registered from the next-state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_libre      <= '0;
            r_modo       <= APAGADO;
            r_adc_inicio <= APAGADO;
            r_cargar     <= APAGADO;
            r_decidir    <= APAGADO;
        end else begin
            r_libre      <= w_libre_sig;
            r_modo       <= w_modo_sig;
            r_adc_inicio <= (w_estado_sig == INICIO);
            r_cargar     <= (w_estado_sig == CARGA);
            r_decidir    <= (w_estado_sig == DECIDE);
        end
    end

`ifdef ALERTA_TIMEOUT_EN
    // Sticky sensor error; only reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_error <= APAGADO;
        end else begin
            r_error <= w_error_sig;
        end
    end

    assign error_sensor = r_error;
`else
    assign error_sensor = APAGADO;
`endif

    assign adc_inicio      = r_adc_inicio;
    assign cargar_alerta   = r_cargar;
    assign activar_decidir = r_decidir;
    assign modo_peligro    = r_modo;

endmodule

// File: tb/tb_secuenciador_alerta.sv
// Self-checking bench for secuenciador_alerta with short periods. Timeout
// scenarios run only when ALERTA_TIMEOUT_EN is defined.
module tb_secuenciador_alerta;

    localparam int PN = 10;
    localparam int PP = 4;
    localparam int TC = 5;
    localparam int NL = 3;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst, ignicion, adc_done, peligro;
    logic adc_inicio, cargar_alerta, activar_decidir, modo_peligro, error_sensor;

    typedef struct {
        int intervalo;
        int n_carga;
        int n_decide;
        bit modo;
        bit err;
    } esperado_t;

    esperado_t cola[$];
    int checks = 0;
    int errors = 0;
    bit modo_m = 0;
    int libre_m = 0;
    bit error_m = 0;

    secuenciador_alerta #(
        .PERIODO_NORMAL (PN),
        .PERIODO_PELIGRO(PP),
        .T_CONV_MAX     (TC),
        .N_LIBRE        (NL),
        .CNT_W          (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ignicion       (ignicion),
        .adc_done       (adc_done),
        .peligro        (peligro),
        .adc_inicio     (adc_inicio),
        .cargar_alerta  (cargar_alerta),
        .activar_decidir(activar_decidir),
        .modo_peligro   (modo_peligro),
        .error_sensor   (error_sensor)
    );

    always #5 clk = ~clk;

    // Reference model of one sample loop; pushes the expected outcome.
    // c = 0 means the ADC never answers (timeout path).
    task automatic modelo_ciclo(input bit pel, input bit ign, input int c);
        esperado_t e;
        if (c == 0) begin
            modo_m  = 1;
            libre_m = 0;
            error_m = 1;
            e = '{intervalo: 1 + TC + PP, n_carga: 0, n_decide: 0, modo: 1'b1, err: 1'b1};
        end else begin
            if (ign) begin
                modo_m  = 0;
                libre_m = 0;
            end else if (pel) begin
                modo_m  = 1;
                libre_m = 0;
            end else begin
                if (libre_m < NL) libre_m++;
                if (libre_m == NL) modo_m = 0;
            end
            e = '{intervalo: 3 + c + (modo_m ? PP : PN), n_carga: 1, n_decide: 1,
                  modo: modo_m, err: error_m};
        end
        cola.push_back(e);
    endtask

    // Runs one loop from an INICIO cycle to the next, with adc_done in
    // CONVIERTE cycle c; returns what the DUT did (intervalo = -1 on timeout).
    task automatic correr_ciclo(input bit pel, input bit ign, input int c,
                                output int intervalo, output int n_carga,
                                output int n_decide, output bit modo, output bit err);
        peligro   = pel;
        ignicion  = ign;
        intervalo = -1;
        n_carga   = 0;
        n_decide  = 0;
        modo      = 0;
        err       = 0;
        for (int j = 0; j < 200; j++) begin
            adc_done = (c != 0) && (j == c);
            @(posedge clk); #1;
            if (cargar_alerta)   n_carga++;
            if (activar_decidir) n_decide++;
            if (adc_inicio) begin
                intervalo = j + 1;
                modo      = modo_peligro;
                err       = error_sensor;
                break;
            end
        end
        adc_done = 0;
    endtask

    task automatic test_reset();
        int k;
        rst = 1; ignicion = 0; adc_done = 0; peligro = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({adc_inicio, cargar_alerta, activar_decidir, modo_peligro, error_sensor} !== 5'b0) begin
            errors++;
            $display("FAIL reset_salidas: got %b expected 00000",
                     {adc_inicio, cargar_alerta, activar_decidir, modo_peligro, error_sensor});
        end
        rst = 0;
        k = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (adc_inicio) begin k = i; break; end
        end
        checks++;
        if (k !== 1) begin
            errors++;
            $display("FAIL reset_primer_inicio: got cycle %0d expected 1", k);
        end
    endtask

    task automatic test_nominal();
        esperado_t e;
        int iv, nc, nd;
        bit m, er;
        for (int i = 0; i < 2; i++) begin
            modelo_ciclo(0, 0, 2);
            correr_ciclo(0, 0, 2, iv, nc, nd, m, er);
            e = cola.pop_front();
            checks++;
            if (iv !== e.intervalo) begin errors++; $display("FAIL nominal_intervalo[%0d]: got %0d expected %0d", i, iv, e.intervalo); end
            checks++;
            if (nc !== e.n_carga) begin errors++; $display("FAIL nominal_cargar[%0d]: got %0d expected %0d", i, nc, e.n_carga); end
            checks++;
            if (nd !== e.n_decide) begin errors++; $display("FAIL nominal_decidir[%0d]: got %0d expected %0d", i, nd, e.n_decide); end
            checks++;
            if (m !== e.modo) begin errors++; $display("FAIL nominal_modo[%0d]: got %0b expected %0b", i, m, e.modo); end
        end
    endtask

    task automatic test_peligro();
        bit pel_t[5] = '{1, 0, 0, 0, 0};
        esperado_t e;
        int iv, nc, nd;
        bit m, er;
        for (int i = 0; i < 5; i++) begin
            modelo_ciclo(pel_t[i], 0, 2);
            correr_ciclo(pel_t[i], 0, 2, iv, nc, nd, m, er);
            e = cola.pop_front();
            checks++;
            if (iv !== e.intervalo) begin errors++; $display("FAIL peligro_intervalo[%0d]: got %0d expected %0d", i, iv, e.intervalo); end
            checks++;
            if (m !== e.modo) begin errors++; $display("FAIL peligro_modo[%0d]: got %0b expected %0b", i, m, e.modo); end
        end
    endtask

    task automatic test_ignicion();
        bit pel_t[3] = '{1, 1, 1};
        bit ign_t[3] = '{1, 0, 1};
        esperado_t e;
        int iv, nc, nd;
        bit m, er;
        for (int i = 0; i < 3; i++) begin
            modelo_ciclo(pel_t[i], ign_t[i], 2);
            correr_ciclo(pel_t[i], ign_t[i], 2, iv, nc, nd, m, er);
            e = cola.pop_front();
            checks++;
            if (iv !== e.intervalo) begin errors++; $display("FAIL ignicion_intervalo[%0d]: got %0d expected %0d", i, iv, e.intervalo); end
            checks++;
            if (m !== e.modo) begin errors++; $display("FAIL ignicion_modo[%0d]: got %0b expected %0b", i, m, e.modo); end
        end
        ignicion = 0;
    endtask

    task automatic test_simultaneo();
        esperado_t e;
        int iv, nc, nd;
        bit m, er;
        modelo_ciclo(0, 0, TC);
        correr_ciclo(0, 0, TC, iv, nc, nd, m, er);
        e = cola.pop_front();
        checks++;
        if (iv !== e.intervalo) begin errors++; $display("FAIL simultaneo_intervalo: got %0d expected %0d", iv, e.intervalo); end
        checks++;
        if (nc !== e.n_carga) begin errors++; $display("FAIL simultaneo_cargar: got %0d expected %0d", nc, e.n_carga); end
        checks++;
        if (er !== e.err) begin errors++; $display("FAIL simultaneo_error: got %0b expected %0b", er, e.err); end
    endtask

`ifdef ALERTA_TIMEOUT_EN
    task automatic test_timeout();
        int c_t[2] = '{0, 2};
        esperado_t e;
        int iv, nc, nd;
        bit m, er;
        for (int i = 0; i < 2; i++) begin
            modelo_ciclo(0, 0, c_t[i]);
            correr_ciclo(0, 0, c_t[i], iv, nc, nd, m, er);
            e = cola.pop_front();
            checks++;
            if (iv !== e.intervalo) begin errors++; $display("FAIL timeout_intervalo[%0d]: got %0d expected %0d", i, iv, e.intervalo); end
            checks++;
            if (nc !== e.n_carga) begin errors++; $display("FAIL timeout_cargar[%0d]: got %0d expected %0d", i, nc, e.n_carga); end
            checks++;
            if (nd !== e.n_decide) begin errors++; $display("FAIL timeout_decidir[%0d]: got %0d expected %0d", i, nd, e.n_decide); end
            checks++;
            if (m !== e.modo) begin errors++; $display("FAIL timeout_modo[%0d]: got %0b expected %0b", i, m, e.modo); end
            checks++;
            if (er !== e.err) begin errors++; $display("FAIL timeout_error[%0d]: got %0b expected %0b", i, er, e.err); end
        end
    endtask
`endif

    task automatic test_reset_conversion();
        esperado_t e;
        int iv, nc, nd, k;
        bit m, er;
        modelo_ciclo(1, 0, 2);
        correr_ciclo(1, 0, 2, iv, nc, nd, m, er);
        e = cola.pop_front();
        checks++;
        if (m !== e.modo) begin errors++; $display("FAIL rstconv_modo_previo: got %0b expected %0b", m, e.modo); end
        peligro = 0;
        @(posedge clk); #2;
        rst = 1;
        #1;
        checks++;
        if ({adc_inicio, cargar_alerta, activar_decidir, modo_peligro, error_sensor} !== 5'b0) begin
            errors++;
            $display("FAIL rstconv_salidas: got %b expected 00000",
                     {adc_inicio, cargar_alerta, activar_decidir, modo_peligro, error_sensor});
        end
        modo_m = 0; libre_m = 0; error_m = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        k = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (adc_inicio) begin k = i; break; end
        end
        checks++;
        if (k !== 1) begin errors++; $display("FAIL rstconv_primer_inicio: got cycle %0d expected 1", k); end
        modelo_ciclo(0, 0, 2);
        correr_ciclo(0, 0, 2, iv, nc, nd, m, er);
        e = cola.pop_front();
        checks++;
        if (iv !== e.intervalo) begin errors++; $display("FAIL rstconv_intervalo: got %0d expected %0d", iv, e.intervalo); end
        checks++;
        if (er !== e.err) begin errors++; $display("FAIL rstconv_error: got %0b expected %0b", er, e.err); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_peligro();
        test_ignicion();
        test_simultaneo();
`ifdef ALERTA_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_conversion();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
